systolic_skew_rearranger: RTL and testbench

SYSTOLIC_SKEW_REARRANGER -- requirements
Module: systolic_skew_rearranger

---
 rtl/systolic_skew_rearranger.sv | 162 ++++++++++++++++
 tb/tb_systolic_skew_rearranger.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_rearranger.sv
`default_nettype none
// ============================================================================
// Module      : systolic_skew_rearranger
// Description : Converts a stream of row vectors into the diagonal (skewed)
//               wavefront expected at the edge of a systolic array. Lane c is
//               delayed by c extra advances through a (c+1)-stage shift
//               register of {valid, data}. A three-state FSM (IDLE, STREAM,
//               DRAIN) tracks the burst and, once the row marked in_last
//               leaves the last lane, pulses done for one cycle.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               in_valid/ready  - row handshake (in_ready = shift_en & !DRAIN)
//               in_data/in_last - packed row vector, final-row marker
//               shift_en        - global advance enable
//               out_data        - skewed lanes, same packing as in_data
//               out_valid       - per-lane valid
//               busy, done      - FSM not IDLE, end-of-burst pulse
// Config      : define SKEW_ZERO_FILL_EN to force bubble slots to carry 0;
//               otherwise bubbles carry the unqualified in_data lane value.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_skew_rearranger #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic                     in_last,
    input  logic                     shift_en,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    output logic                     busy,
    output logic                     done
);

    // Counter must hold NUM_CH-1; keep at least one bit for NUM_CH=1.
    localparam int CNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               advance;
    logic               accept;

    assign advance  = shift_en;
    assign in_ready = shift_en && (state_q != ST_DRAIN);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // done is a single-cycle pulse: it drops on the next edge even if
        // the pipeline is stalled.
        done_d  = 1'b0;
        if (advance) begin
            case (state_q)
                ST_IDLE, ST_STREAM: begin
                    if (accept) begin
                        if (in_last) begin
                            if (NUM_CH == 1) begin
                                // Single lane: the last row is on the output
                                // right after this advance.
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_DRAIN;
                                cnt_d   = CNT_W'(NUM_CH - 1);
                            end
                        end else begin
                            state_d = ST_STREAM;
                        end
                    end
                end
                ST_DRAIN: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Skew lanes: lane c holds c+1 stages packed LSB-first (stage 0 in the
    // low DATA_W bits). A left shift by one stage advances the lane.
    // ------------------------------------------------------------------------
    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_lane
            localparam int LW = (c + 1) * DATA_W;
            localparam int VW = c + 1;

            logic [LW-1:0]     data_q, data_d;
            logic [VW-1:0]     vld_q, vld_d;
            logic [DATA_W-1:0] lane_in;
            logic [DATA_W-1:0] lane_new;

            assign lane_in = in_data[c*DATA_W +: DATA_W];

`ifdef SKEW_ZERO_FILL_EN
            assign lane_new = accept ? lane_in : '0;
`else
            assign lane_new = lane_in;
`endif

            always_comb begin
                data_d = data_q;
                vld_d  = vld_q;
                if (advance) begin
                    data_d = (data_q << DATA_W) | LW'(lane_new);
                    vld_d  = (vld_q << 1) | VW'(accept);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q <= '0;
                    vld_q  <= '0;
                end else begin
                    data_q <= data_d;
                    vld_q  <= vld_d;
                end
            end

            assign out_data[c*DATA_W +: DATA_W] = data_q[c*DATA_W +: DATA_W];
            assign out_valid[c]                 = vld_q[c];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_rearranger.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_skew_rearranger
// Description : Directed self-checking bench for systolic_skew_rearranger
//               (NUM_CH=4, DATA_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_rearranger;

    localparam int DATA_W = 8;
    localparam int NUM_CH = 4;

`ifdef SKEW_ZERO_FILL_EN
    localparam logic [7:0] BUB = 8'h00;
`else
    localparam logic [7:0] BUB = 8'hFF;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        shift_en;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    logic done_seen;

    systolic_skew_rearranger #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .shift_en  (shift_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        shift_en = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        #2;
        // Reset state
        chk("rst_out_data",  out_data, 32'h0);
        chk("rst_out_valid", {28'h0, out_valid}, 32'h0);
        chk("rst_busy",      {31'h0, busy}, 32'h0);
        chk("rst_done",      {31'h0, done}, 32'h0);
        chk("rst_ready_en",  {31'h0, in_ready}, 32'h1);
        shift_en = 1'b0;
        #1;
        chk("rst_ready_dis", {31'h0, in_ready}, 32'h0);
        shift_en = 1'b1;
        repeat (2) adv();
        rst = 1'b0;
        #2;

        // Single row with in_last
        in_valid = 1'b1; in_last = 1'b1; in_data = 32'h04030201;
        chk("t1_ready", {31'h0, in_ready}, 32'h1);
        adv();
        in_valid = 1'b0; in_last = 1'b0; in_data = 32'h0;
        chk("t1_a1_valid", {28'h0, out_valid}, 32'h1);
        chk("t1_a1_data",  out_data, 32'h00000001);
        chk("t1_a1_busy",  {31'h0, busy}, 32'h1);
        chk("t1_a1_ready", {31'h0, in_ready}, 32'h0);
        adv();
        chk("t1_a2_valid", {28'h0, out_valid}, 32'h2);
        chk("t1_a2_data",  out_data, 32'h00000200);
        adv();
        chk("t1_a3_valid", {28'h0, out_valid}, 32'h4);
        chk("t1_a3_data",  out_data, 32'h00030000);
        chk("t1_a3_done",  {31'h0, done}, 32'h0);
        adv();
        chk("t1_a4_valid", {28'h0, out_valid}, 32'h8);
        chk("t1_a4_data",  out_data, 32'h04000000);
        chk("t1_a4_done",  {31'h0, done}, 32'h1);
        chk("t1_a4_busy",  {31'h0, busy}, 32'h0);
        adv();
        chk("t1_a5_done",  {31'h0, done}, 32'h0);
        chk("t1_a5_valid", {28'h0, out_valid}, 32'h0);

        // Three back-to-back rows, staircase
        in_valid = 1'b1; in_data = 32'h11111111;
        adv();
        chk("t2_s1", {28'h0, out_valid}, 32'h1);
        chk("t2_busy1", {31'h0, busy}, 32'h1);
        in_data = 32'h22222222;
        adv();
        chk("t2_s2", {28'h0, out_valid}, 32'h3);
        in_data = 32'h33333333; in_last = 1'b1;
        adv();
        chk("t2_s3", {28'h0, out_valid}, 32'h7);
        chk("t2_d3", out_data, 32'h00112233);
        in_valid = 1'b0; in_last = 1'b0; in_data = 32'h0;
        adv();
        chk("t2_s4", {28'h0, out_valid}, 32'hE);
        adv();
        chk("t2_s5", {28'h0, out_valid}, 32'hC);
        chk("t2_done5", {31'h0, done}, 32'h0);
        chk("t2_busy5", {31'h0, busy}, 32'h1);
        adv();
        chk("t2_s6", {28'h0, out_valid}, 32'h8);
        chk("t2_d6", out_data, 32'h33000000);
        chk("t2_done6", {31'h0, done}, 32'h1);
        chk("t2_busy6", {31'h0, busy}, 32'h0);

        // Stall mid-burst (STREAM) and during DRAIN
        in_valid = 1'b1; in_data = 32'h0A0A0A0A;
        adv();
        in_data = 32'h0B0B0B0B;
        adv();
        chk("t3_pre_valid", {28'h0, out_valid}, 32'h3);
        chk("t3_pre_data",  out_data, 32'h00000A0B);
        shift_en = 1'b0; in_data = 32'h0C0C0C0C; in_last = 1'b1;
        #1;
        chk("t3_stall_ready", {31'h0, in_ready}, 32'h0);
        repeat (5) adv();
        chk("t3_hold_valid", {28'h0, out_valid}, 32'h3);
        chk("t3_hold_data",  out_data, 32'h00000A0B);
        chk("t3_hold_busy",  {31'h0, busy}, 32'h1);
        chk("t3_hold_done",  {31'h0, done}, 32'h0);
        shift_en = 1'b1;
        #1;
        chk("t3_resume_ready", {31'h0, in_ready}, 32'h1);
        adv();
        chk("t3_r1_valid", {28'h0, out_valid}, 32'h7);
        chk("t3_r1_data",  out_data, 32'h000A0B0C);
        in_valid = 1'b0; in_last = 1'b0; in_data = 32'h0;
        adv();
        chk("t3_r2_valid", {28'h0, out_valid}, 32'hE);
        chk("t3_r2_data",  out_data, 32'h0A0B0C00);
        adv();
        chk("t3_r3_data",  out_data, 32'h0B0C0000);
        shift_en = 1'b0;
        repeat (3) adv();
        chk("t3_dstall_valid", {28'h0, out_valid}, 32'hC);
        chk("t3_dstall_done",  {31'h0, done}, 32'h0);
        chk("t3_dstall_busy",  {31'h0, busy}, 32'h1);
        shift_en = 1'b1;
        adv();
        chk("t3_r4_valid", {28'h0, out_valid}, 32'h8);
        chk("t3_r4_data",  out_data, 32'h0C000000);
        chk("t3_r4_done",  {31'h0, done}, 32'h1);

        // in_valid held through DRAIN
        in_valid = 1'b1; in_last = 1'b1; in_data = 32'h55555555;
        adv();
        in_last = 1'b0; in_data = 32'h66666666;
        for (int i = 0; i < 3; i++) begin
            chk("t4_drain_ready", {31'h0, in_ready}, 32'h0);
            adv();
        end
        chk("t4_done",   {31'h0, done}, 32'h1);
        chk("t4_valid",  {28'h0, out_valid}, 32'h8);
        chk("t4_lane3",  {24'h0, out_data[31:24]}, 32'h55);
        chk("t4_ready",  {31'h0, in_ready}, 32'h1);
        in_last = 1'b1;
        adv();
        chk("t4_acc_valid", {28'h0, out_valid}, 32'h1);
        chk("t4_acc_lane0", {24'h0, out_data[7:0]}, 32'h66);
        chk("t4_acc_busy",  {31'h0, busy}, 32'h1);
        in_valid = 1'b0; in_last = 1'b0; in_data = 32'h0;
        repeat (3) adv();
        chk("t4_done2",  {31'h0, done}, 32'h1);
        chk("t4_lane3b", {24'h0, out_data[31:24]}, 32'h66);

        // Reset mid-burst
        in_valid = 1'b1; in_data = 32'h11111111;
        adv();
        in_data = 32'h22222222;
        adv();
        chk("t5_pre_valid", {28'h0, out_valid}, 32'h3);
        rst = 1'b1;
        #1;
        chk("t5_valid", {28'h0, out_valid}, 32'h0);
        chk("t5_data",  out_data, 32'h0);
        chk("t5_busy",  {31'h0, busy}, 32'h0);
        chk("t5_done",  {31'h0, done}, 32'h0);
        chk("t5_ready", {31'h0, in_ready}, 32'h1);
        in_valid = 1'b0; in_data = 32'h0;
        adv();
        rst = 1'b0;
        done_seen = 1'b0;
        repeat (6) begin
            adv();
            if (done) done_seen = 1'b1;
        end
        chk("t5_no_done", {31'h0, done_seen}, 32'h0);
        chk("t5_post_valid", {28'h0, out_valid}, 32'h0);
        chk("t5_post_busy",  {31'h0, busy}, 32'h0);

        // Row, bubble (in_data all ones), row
        in_valid = 1'b1; in_data = 32'h01010101;
        adv();
        chk("t6_a1_valid", {28'h0, out_valid}, 32'h1);
        chk("t6_a1_lane0", {24'h0, out_data[7:0]}, 32'h01);
        in_valid = 1'b0; in_data = 32'hFFFFFFFF;
        adv();
        chk("t6_a2_valid", {28'h0, out_valid}, 32'h2);
        chk("t6_a2_lane0", {24'h0, out_data[7:0]}, {24'h0, BUB});
        in_valid = 1'b1; in_data = 32'h02020202; in_last = 1'b1;
        adv();
        chk("t6_a3_valid", {28'h0, out_valid}, 32'h5);
        chk("t6_a3_lane1", {24'h0, out_data[15:8]}, {24'h0, BUB});
        in_valid = 1'b0; in_last = 1'b0; in_data = 32'h0;
        adv();
        chk("t6_a4_valid", {28'h0, out_valid}, 32'hA);
        adv();
        chk("t6_a5_valid", {28'h0, out_valid}, 32'h4);
        chk("t6_a5_lane3", {24'h0, out_data[31:24]}, {24'h0, BUB});
        chk("t6_a5_done",  {31'h0, done}, 32'h0);
        adv();
        chk("t6_a6_valid", {28'h0, out_valid}, 32'h8);
        chk("t6_a6_lane3", {24'h0, out_data[31:24]}, 32'h02);
        chk("t6_a6_done",  {31'h0, done}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
